// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 32-entry register bank.
// Supports register widths up to REG_W_MAX bits through get_reg().
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W_MAX  = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Extract register idx of width w from a flattened bus.
  // The caller zero-extends the bus to NUM_REGS*REG_W_MAX bits.
  function automatic logic [REG_W_MAX-1:0] get_reg(
    input logic [NUM_REGS*REG_W_MAX-1:0] bus,
    input int unsigned                   idx,
    input int unsigned                   w
  );
    logic [NUM_REGS*REG_W_MAX-1:0] sh;
    logic [REG_W_MAX-1:0]          mask;
    sh   = bus >> (idx * w);
    mask = (w >= REG_W_MAX) ? '1
         : ((REG_W_MAX'(1) << w) - REG_W_MAX'(1));
    return sh[REG_W_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile32_writer_decoder5to32.sv
// 5-to-32 one-hot decoder with enable.
// Ports: addr (5b), ena, oh (32b one-hot, all zero when ena=0).
module decoder5to32
  import regfile_pkg::*;
(
  input  reg_addr_t             addr,
  input  logic                  ena,
  output logic [NUM_REGS-1:0]   oh
);

  always_comb begin
    oh = '0;
    if (ena) begin
      oh[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile32_writer.sv
// Write side of the 32-entry register bank with busy scoreboard.
// Ports: clk, rst_n (async low); wr_ena/wr_addr/wr_data write-back;
//   rsv_ena/rsv_addr reservation; regs (32*N flat), busy (32),
//   stray_wr (pulse after write-back to a non-busy register).
// Optional: define REGFILE_WR_BYPASS_EN to forward wr_data onto regs
//   in the same cycle it is written.
module regfile32_writer
  import regfile_pkg::*;
#(
  parameter int N        = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_ena,
  input  logic [4:0]            wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic                  rsv_ena,
  input  logic [4:0]            rsv_addr,
  output logic [NUM_REGS*N-1:0] regs,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  stray_wr
);

  logic [NUM_REGS-1:0]        wr_oh;
  logic [NUM_REGS-1:0]        rsv_oh;
  logic [NUM_REGS-1:0]        wr_en;
  logic [NUM_REGS-1:0]        rsv_en;
  logic [NUM_REGS-1:0]        keep_mask;

  logic [NUM_REGS-1:0][N-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        busy_q, busy_d;
  logic                       stray_q, stray_d;
  logic                       wr_to_zero;

  decoder5to32 u_wr_dec (
    .addr (wr_addr),
    .ena  (wr_ena),
    .oh   (wr_oh)
  );

  decoder5to32 u_rsv_dec (
    .addr (rsv_addr),
    .ena  (rsv_ena),
    .oh   (rsv_oh)
  );

  // Register 0 drops out of both decoders when hardwired.
  always_comb begin
    keep_mask    = '1;
    keep_mask[0] = ~ZERO_REG;
    wr_en        = wr_oh & keep_mask;
    rsv_en       = rsv_oh & keep_mask;
    wr_to_zero   = ZERO_REG && (wr_addr == '0);
  end

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en[k]) begin
        regs_d[k] = wr_data;
      end
    end
  end

  // A same-edge reservation overrides the write-back clear.
  always_comb begin
    busy_d  = (busy_q & ~wr_en) | rsv_en;
    stray_d = wr_ena && !wr_to_zero && !busy_q[wr_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      busy_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  always_comb begin
    regs = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en[k]) begin
        regs[k*N +: N] = wr_data;
      end
    end
  end
`else
  assign regs = regs_q;
`endif

  assign busy     = busy_q;
  assign stray_wr = stray_q;

endmodule

// File: tb/tb_regfile32_writer.sv
// Self-checking bench for regfile32_writer.
// Table of write/reserve vectors with expectations queued per edge.
module tb_regfile32_writer;
  import regfile_pkg::*;

  localparam int N = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_ena;
  logic [4:0]            wr_addr;
  logic [N-1:0]          wr_data;
  logic                  rsv_ena;
  logic [4:0]            rsv_addr;
  logic [NUM_REGS*N-1:0] regs;
  logic [NUM_REGS-1:0]   busy;
  logic                  stray_wr;

  int checks;
  int failures;

  regfile32_writer #(.N(N), .ZERO_REG(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_ena  (rsv_ena),
    .rsv_addr (rsv_addr),
    .regs     (regs),
    .busy     (busy),
    .stray_wr (stray_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  ca;
    logic [31:0] exp_d;
    logic        exp_b;
    logic        exp_s;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];

  function automatic logic [31:0] slot(input int unsigned k);
    logic [NUM_REGS*REG_W_MAX-1:0] ext;
    logic [REG_W_MAX-1:0]          r;
    ext = '0;
    ext[NUM_REGS*N-1:0] = regs;
    r = get_reg(ext, k, N);
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    wr_ena   = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_ena  = v.re;
    rsv_addr = v.ra;
    sb_q.push_back(v);
  endtask

  task automatic run_vec(input int i);
    vec_t e;
    drive(vecs[i]);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("v%0d slot%0d", i, e.ca), 64'(slot(e.ca)), 64'(e.exp_d));
    chk($sformatf("v%0d busy%0d", i, e.ca), 64'(busy[e.ca]), 64'(e.exp_b));
    chk($sformatf("v%0d stray", i), 64'(stray_wr), 64'(e.exp_s));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    //        we  wa  wd            re  ra  ca  exp_d         b  s
    vecs[0]  = '{0, 0, 0,            1, 3,  3,  0,            1, 0};
    vecs[1]  = '{0, 0, 0,            0, 0,  3,  0,            1, 0};
    vecs[2]  = '{1, 3, 32'hDEADBEEF, 0, 0,  3,  32'hDEADBEEF, 0, 0};
    vecs[3]  = '{1, 9, 32'h12,       0, 0,  9,  32'h12,       0, 1};
    vecs[4]  = '{0, 0, 0,            0, 0,  9,  32'h12,       0, 0};
    vecs[5]  = '{0, 0, 0,            1, 4,  4,  0,            1, 0};
    vecs[6]  = '{1, 4, 32'h55,       1, 4,  4,  32'h55,       1, 0};
    vecs[7]  = '{1, 4, 32'h66,       0, 0,  4,  32'h66,       0, 0};
    vecs[8]  = '{0, 0, 0,            1, 0,  0,  0,            0, 0};
    vecs[9]  = '{1, 0, 32'hFFFFFFFF, 0, 0,  0,  0,            0, 0};
    vecs[10] = '{1, 11, 32'h77,      1, 10, 11, 32'h77,       0, 1};
    vecs[11] = '{0, 0, 0,            0, 0,  10, 0,            1, 0};
    vecs[12] = '{0, 0, 0,            1, 10, 10, 0,            1, 0};
    vecs[13] = '{1, 10, 32'hABC,     0, 0,  10, 32'hABC,      0, 0};
    vecs[14] = '{1, 10, 32'hDEF,     0, 0,  10, 32'hDEF,      0, 1};
    vecs[15] = '{1, 31, 32'hA5A5A5A5, 0, 0, 31, 32'hA5A5A5A5, 0, 1};

    rst_n = 1'b0;
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_ena = 1'b0; rsv_addr = '0;
    #1;
    chk("rst regs", 64'(regs == '0), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst stray", 64'(stray_wr), 64'd0);
    #12;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_vec(i);
    end
    chk("hold slot3", 64'(slot(3)), 64'hDEADBEEF);
    chk("busy vec", 64'(busy), 64'd0);

    // Same-cycle visibility of a write in progress.
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = 5'd31;
    wr_data = 32'h5A5A5A5A;
    rsv_ena = 1'b0;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("bypass pre", 64'(slot(31)), 64'h5A5A5A5A);
`else
    chk("bypass pre", 64'(slot(31)), 64'hA5A5A5A5);
`endif
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    #1;
    chk("bypass r0", 64'(slot(0)), 64'd0);
    wr_addr = 5'd31;
    wr_data = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    chk("bypass post", 64'(slot(31)), 64'h5A5A5A5A);

    // Load and reserve 5 and 7, then a stray write to 8.
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'h50;
    rsv_ena = 1'b1; rsv_addr = 5'd5;
    @(negedge clk);
    wr_addr = 5'd7; wr_data = 32'h70; rsv_addr = 5'd7;
    @(negedge clk);
    wr_addr = 5'd8; wr_data = 32'h80; rsv_ena = 1'b0;
    @(posedge clk);
    #1;
    chk("pre slot5", 64'(slot(5)), 64'h50);
    chk("pre slot7", 64'(slot(7)), 64'h70);
    chk("pre busy", 64'(busy), 64'h0000_00A0);
    chk("pre stray", 64'(stray_wr), 64'd1);
    wr_ena = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async regs", 64'(regs == '0), 64'd1);
    chk("async busy", 64'(busy), 64'd0);
    chk("async stray", 64'(stray_wr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ena = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    @(posedge clk);
    #1;
    chk("post rst slot2", 64'(slot(2)), 64'h22);
    chk("post rst stray", 64'(stray_wr), 64'd1);
    chk("post rst slot5", 64'(slot(5)), 64'd0);
    wr_ena = 1'b0;
    @(posedge clk);
    #1;
    chk("stray drop", 64'(stray_wr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
